am2940_sequencer: RTL
=====================

# am2940_sequencer

Master-side controller that drives the AM2940 address generator through a complete DMA job. On a `start` request it:
- programs the control register and reads it back to verify it;
- loads the address and word-count registers, then re-initialises the counters;
- steps the counters once per acknowledged memory transfer until the generator raises DONE.

It sits between the system job interface and the generator's I2..0, data bus, CIA/CIW and DONE pins.

## Interface
- No parameters; all datapaths are 8 bits, matching the generator.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  job request, sampled only in IDLE.
- `abort`  in  1  cancel the current job.
- `mode`  in  2  value for control register CR[1:0]; 2'b11 is illegal.
- `addr_dec`  in  1  value for CR[2] (address decrement).
- `start_addr`  in  8  first transfer address.
- `word_count`  in  8  transfer count; 0 is illegal.
- `I20`  out  3  generator instruction.
- `d_out`  out  8  data driven to the generator bus.
- `d_oe`  out  1  `d_out` valid / bus drive enable.
- `rd_data`  in  8  generator data output during read instructions.
- `cia`, `ciw`  out  1  counter enables, active-high (count when 1).
- `done_in`  in  1  generator DONE.
- `xfer_req`  out  1  memory transfer request.
- `xfer_ack`  in  1  memory transfer completed this cycle.
- `busy`  out  1  job in progress.
- `done`  out  1  one-cycle job-complete pulse.
- `err`  out  1  sticky error flag.
- `xfer_count`  out  8  transfers completed in the current job.

## Operation
- Instruction encodings:
  - 000 write CR (data bits 2:0)
  - 001 read CR
  - 100 re-init counters
  - 101 load address
  - 110 load word count
  - 111 enable counters
- All outputs are Moore, derived from the registered state.
- Whenever the sequencer is not issuing a command: `I20`=111, `cia`=`ciw`=0 (generator holds), `d_oe`=0, `d_out`=0.
- States: IDLE, WR_CR, RD_CR, LD_ADDR, LD_WC, REINIT, XFER, STEP, FIN, ERR.
- IDLE → WR_CR when `start`=1:
  - clears `err` and `xfer_count`;
  - goes to ERR instead if `mode`=11 or `word_count`=0.
- Start parameters are latched when `start` is accepted; later changes to the inputs are ignored for the rest of the job.
- WR_CR: `I20`=000, `d_out`={5'b0,`addr_dec`,`mode`}, `d_oe`=1.
- RD_CR: `I20`=001, `d_oe`=0.
  - `rd_data`[2:0] ≠ latched CR → ERR.
  - Otherwise → LD_ADDR.
- LD_ADDR: `I20`=101, `d_out`=`start_addr`, `d_oe`=1.
- LD_WC: `I20`=110, `d_out`=`word_count`, `d_oe`=1.
- REINIT: `I20`=100, then → XFER.
- XFER: `xfer_req`=1, generator held.
  - Stays in XFER until `xfer_ack`=1, then → STEP.
- STEP: `I20`=111, `cia`=`ciw`=1 for exactly one cycle; `xfer_count` increments, wrapping mod 256.
  - `done_in` sampled this cycle = 1 → FIN.
  - Otherwise → XFER.
- FIN: `done`=1 for one cycle → IDLE.
- ERR: sets `err` → IDLE next cycle. `err` stays set until the next accepted `start`.
- `abort`=1 in any non-IDLE state → IDLE next edge:
  - no `done` pulse, `err` unchanged;
  - takes priority over `xfer_ack`; no count step occurs.
- `busy`=1 in every state except IDLE.

## Timing
- Reset values: state IDLE, `I20`=111, `d_out`=0, `d_oe`=0, `cia`=`ciw`=0, `xfer_req`=0, `busy`=0, `done`=0, `err`=0, `xfer_count`=0.
- `start` accepted at edge k: WR_CR occupies cycle k+1, then RD_CR k+2, LD_ADDR k+3, LD_WC k+4, REINIT k+5. `xfer_req` first rises in cycle k+6.
- Each transfer takes at least 2 cycles (XFER with immediate ack, then STEP). `xfer_req` is low during STEP.
- `done` rises in the cycle after the final STEP. `busy` falls on the cycle after FIN.
- Reset asserted mid-job: all outputs return to their reset values immediately (asynchronous). The generator is left holding.

## Structure
- Shared package `am2940_pkg`:
  - instruction opcode constants;
  - CR mode constants (00, 01, 10);
  - state enum.
- Single module; no sub-module is warranted. The `xfer_count` counter and parameter latches are inline.

## Test plan
- Basic job: `mode`=00, `addr_dec`=0, `start_addr`=0x10, `word_count`=3, `xfer_ack` immediate, generator model raises DONE on the 3rd STEP → exactly 3 STEP cycles, `done` pulse, `xfer_count`=3, `busy` low after.
- Readback failure: model returns `rd_data`=0x05 for CR written as 0x01 → ERR, `err`=1, no `xfer_req`; next valid `start` clears `err`.
- Illegal parameters: `start` with `mode`=11, and separately with `word_count`=0 → IDLE→ERR→IDLE; `err`=1, `I20` never leaves 111.
- Slow memory: `xfer_ack` delayed 4 cycles per transfer → `xfer_req` held high for 5 cycles each time; `cia`/`ciw` pulse exactly once per ack.
- Abort coinciding with `xfer_ack` in XFER → IDLE, no STEP, no `done`, `xfer_count` unchanged.
- Asynchronous reset asserted in STEP → all outputs return to reset values before the next clock edge.

Source files
------------

// File: rtl/am2940_pkg.sv
// Shared definitions for the AM2940 DMA sequencer: generator opcodes,
// control-register modes and the sequencer state type.
package am2940_pkg;

  // Generator instruction opcodes driven on I2..0
  localparam logic [2:0] OP_WR_CR   = 3'b000;
  localparam logic [2:0] OP_RD_CR   = 3'b001;
  localparam logic [2:0] OP_REINIT  = 3'b100;
  localparam logic [2:0] OP_LD_ADDR = 3'b101;
  localparam logic [2:0] OP_LD_WC   = 3'b110;
  localparam logic [2:0] OP_ENABLE  = 3'b111;

  // Control register CR[1:0] transfer modes; 2'b11 is not a legal mode
  localparam logic [1:0] MODE_0       = 2'b00;
  localparam logic [1:0] MODE_1       = 2'b01;
  localparam logic [1:0] MODE_2       = 2'b10;
  localparam logic [1:0] MODE_ILLEGAL = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_CR,
    S_RD_CR,
    S_LD_ADDR,
    S_LD_WC,
    S_REINIT,
    S_XFER,
    S_STEP,
    S_FIN,
    S_ERR
  } state_t;

  // A job can only run with a legal mode and a non-zero word count
  function automatic logic params_legal(input logic [1:0] mode, input logic [7:0] word_count);
    return (mode != MODE_ILLEGAL) && (word_count != 8'd0);
  endfunction

endpackage

// File: rtl/am2940_sequencer.sv
// Master-side controller that programs an AM2940 address generator and
// steps it through one DMA job per accepted start request.
module am2940_sequencer
  import am2940_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [1:0] mode,
  input  logic       addr_dec,
  input  logic [7:0] start_addr,
  input  logic [7:0] word_count,
  output logic [2:0] I20,
  output logic [7:0] d_out,
  output logic       d_oe,
  input  logic [7:0] rd_data,
  output logic       cia,
  output logic       ciw,
  input  logic       done_in,
  output logic       xfer_req,
  input  logic       xfer_ack,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] xfer_count
);

  state_t     state_q, state_d;
  logic [2:0] cr_q;
  logic [7:0] addr_q;
  logic [7:0] wc_q;
  logic       err_q;
  logic [7:0] count_q;

  // Only CR[2:0] is meaningful on readback
  logic unused_rd_hi;
  assign unused_rd_hi = ^rd_data[7:3];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; abort overrides every transition out of a busy state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = params_legal(mode, word_count) ? S_WR_CR : S_ERR;
      S_WR_CR:   state_d = S_RD_CR;
      S_RD_CR:   state_d = (rd_data[2:0] != cr_q) ? S_ERR : S_LD_ADDR;
      S_LD_ADDR: state_d = S_LD_WC;
      S_LD_WC:   state_d = S_REINIT;
      S_REINIT:  state_d = S_XFER;
      S_XFER:    if (xfer_ack) state_d = S_STEP;
      S_STEP:    state_d = done_in ? S_FIN : S_XFER;
      S_FIN:     state_d = S_IDLE;
      S_ERR:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (abort && state_q != S_IDLE) state_d = S_IDLE;
  end

  // Job parameter latches, sticky error flag and transfer counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cr_q    <= '0;
      addr_q  <= '0;
      wc_q    <= '0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      if (state_q == S_IDLE && start) begin
        cr_q    <= {addr_dec, mode};
        addr_q  <= start_addr;
        wc_q    <= word_count;
        err_q   <= 1'b0;
        count_q <= '0;
      end
      if (!abort) begin
        if (state_q == S_ERR)  err_q   <= 1'b1;
        if (state_q == S_STEP) count_q <= count_q + 8'd1;
      end
    end
  end

  // Moore output decode; the generator holds whenever no command is issued
  always_comb begin
    I20      = OP_ENABLE;
    d_out    = '0;
    d_oe     = 1'b0;
    cia      = 1'b0;
    ciw      = 1'b0;
    xfer_req = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_WR_CR: begin
        I20   = OP_WR_CR;
        d_out = {5'b0, cr_q};
        d_oe  = 1'b1;
      end
      S_RD_CR:   I20 = OP_RD_CR;
      S_LD_ADDR: begin
        I20   = OP_LD_ADDR;
        d_out = addr_q;
        d_oe  = 1'b1;
      end
      S_LD_WC: begin
        I20   = OP_LD_WC;
        d_out = wc_q;
        d_oe  = 1'b1;
      end
      S_REINIT:  I20 = OP_REINIT;
      S_XFER:    xfer_req = 1'b1;
      S_STEP: begin
        cia = 1'b1;
        ciw = 1'b1;
      end
      S_FIN:     done = 1'b1;
      default:   ;
    endcase
  end

  assign busy       = (state_q != S_IDLE);
  assign err        = err_q;
  assign xfer_count = count_q;

endmodule
